// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle for
// MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO writes, and flush/reset abort.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module muldiv_ctrl #(
  parameter int W = `WORD_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   md_op,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int         CW       = $clog2(W) + 1;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_q;
  logic [W-1:0]   op1_q;
  logic [W-1:0]   opb_q;
  logic [2*W:0]   acc;
  logic           neg_res, neg_rem, div_zero;

  logic           start_md, start_mt, in_signed, is_mul_q;
  logic [W-1:0]   mag1, mag2;
  logic [W:0]     mul_sum, div_upper;
  logic [2*W:0]   div_shift, mul_step, div_step;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   res_hi, res_lo;

  assign busy      = (state != IDLE);
  assign start_md  = (state == IDLE) && start && !flush &&
                     (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign start_mt  = (state == IDLE) && start && !flush;
  assign in_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
  assign mag1      = (in_signed && op1[W-1]) ? -op1 : op1;
  assign mag2      = (in_signed && op2[W-1]) ? -op2 : op2;
  assign is_mul_q  = (op_q == OP_MULT) || (op_q == OP_MULTU);

  // Both algorithms run on magnitudes: acc low half starts as the multiplier
  // or dividend, opb_q holds the multiplicand or divisor.
  assign mul_sum   = acc[2*W:W] + {1'b0, (acc[0] ? opb_q : {W{1'b0}})};
  assign mul_step  = {1'b0, mul_sum, acc[W-1:1]};
  assign div_shift = {acc[2*W-1:0], 1'b0};
  assign div_upper = div_shift[2*W:W];
  assign div_step  = (div_upper >= {1'b0, opb_q})
                   ? {div_upper - {1'b0, opb_q}, div_shift[W-1:1], 1'b1}
                   : div_shift;
  assign prod_s    = neg_res ? -acc[2*W-1:0] : acc[2*W-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_md) state_next = CALC;
      CALC:    if (cnt == CW'(W - 1)) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    res_hi = prod_s[2*W-1:W];
    res_lo = prod_s[W-1:0];
    if (!is_mul_q) begin
      if (div_zero) begin
        res_hi = op1_q;
        res_lo = {W{1'b1}};
      end else begin
        res_hi = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
        res_lo = neg_res ? -acc[W-1:0]   : acc[W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: operand/counter registers are reset too, so a post-reset state
  // never depends on a discarded operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      op1_q    <= '0;
      opb_q    <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (start_md) begin
      cnt      <= '0;
      op_q     <= md_op;
      op1_q    <= op1;
      opb_q    <= mag2;
      acc      <= {{(W+1){1'b0}}, mag1};
      neg_res  <= in_signed && (op1[W-1] ^ op2[W-1]);
      neg_rem  <= in_signed && op1[W-1];
      div_zero <= (op2 == '0);
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= is_mul_q ? mul_step : div_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == FIN && !flush) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end else if (start_mt && md_op == OP_MTHI) begin
        hi <= op1;
      end else if (start_mt && md_op == OP_MTLO) begin
        lo <= op1;
      end
    end
  end

endmodule
